lcd_text_num_seq: RTL and testbench

- Parametrised successor to the fixed-string character sequencer feeding the LCD character renderer (show_char).
- After LCD init, draws a configurable static text label, then a live unsigned decimal number field, one glyph at a time over the show_char_flag/show_char_done handshake.
- Afterwards, redraws only the number field whenever a new value arrives.
- Sits between lcd_init/lcd_ctrl and the show_char renderer.

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/bin2bcd_seq.sv | 49 ++++
 rtl/lcd_text_num_seq.sv | 196 +++++++++++++++++++
 tb/tb_lcd_text_num_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and sequencer state encoding for the LCD character drawing blocks.
package lcd_pkg;

  localparam int ASCII_SPACE = 32;
  localparam int ASCII_ZERO  = 48;

  localparam int PITCH_12X6  = 6;
  localparam int HEIGHT_12X6 = 12;
  localparam int PITCH_16X8  = 8;
  localparam int HEIGHT_16X8 = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STR_REQ  = 3'd1,
    ST_STR_WAIT = 3'd2,
    ST_CONV     = 3'd3,
    ST_NUM_REQ  = 3'd4,
    ST_NUM_WAIT = 3'd5,
    ST_HOLD     = 3'd6
  } seq_state_t;

  function automatic int font_pitch(input int en_size);
    return (en_size != 0) ? PITCH_16X8 : PITCH_12X6;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, DATA_W cycles per value.
module bin2bcd_seq #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_W-1:0]       bin_q;
  logic [DATA_W-1:0]       bin_nx;
  logic [4*NUM_DIGITS-1:0] bcd_adj;
  logic [4*NUM_DIGITS-1:0] bcd_nx;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    {bcd_nx, bin_nx} = {bcd_adj, bin_q} << 1;
  end

  // done marks the final shift cycle, so bcd is complete from the next cycle on
  assign done = (cnt_q == CNT_W'(1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      bin_q <= '0;
      bcd   <= '0;
    end else if (start) begin
      cnt_q <= CNT_W'(DATA_W);
      bin_q <= bin;
      bcd   <= '0;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      bin_q <= bin_nx;
      bcd   <= bcd_nx;
    end
  end

endmodule

// File: rtl/lcd_text_num_seq.sv
// Draws a static text label then a live decimal number field through the
// show_char glyph handshake; later values redraw only the number field.
//  state    | meaning
//  IDLE     | waiting for LCD init
//  STR_REQ  | issue one label glyph
//  STR_WAIT | wait for label glyph done
//  CONV     | binary to BCD conversion of the captured value
//  NUM_REQ  | issue one number glyph
//  NUM_WAIT | wait for number glyph done
//  HOLD     | frame shown, waiting for a new value
module lcd_text_num_seq
  import lcd_pkg::*;
#(
  parameter int                   EN_SIZE       = 0,
  parameter int                   STR_LEN       = 12,
  parameter logic [8*STR_LEN-1:0] TEXT          = "REDSTONEBOOK",
  parameter int                   STR_X0        = 72,
  parameter int                   STR_Y0        = 16,
  parameter int                   NUM_X0        = 8,
  parameter int                   NUM_Y0        = 48,
  parameter int                   DATA_W        = 16,
  parameter int                   NUM_DIGITS    = 5,
  parameter int                   ZERO_SUPPRESS = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_done,
  input  logic              show_char_done,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              en_size,
  output logic              show_char_flag,
  output logic [6:0]        ascii_num,
  output logic [8:0]        start_x,
  output logic [8:0]        start_y,
  output logic              busy,
  output logic              frame_done
);

  if (pow10(NUM_DIGITS) <= (64'd1 << DATA_W)) begin : g_bad_digits
    $error("NUM_DIGITS cannot hold every DATA_W value");
  end
  if (STR_LEN < 1 || STR_LEN > 32) begin : g_bad_str_len
    $error("STR_LEN must be 1..32");
  end

  localparam int         DIG_W = $clog2(NUM_DIGITS + 1);
  localparam logic [8:0] PITCH = 9'(font_pitch(EN_SIZE));

  seq_state_t              state_q, state_d;
  logic [4:0]              str_idx_q, str_idx_d;
  logic [DIG_W-1:0]        dig_idx_q, dig_idx_d;
  logic [DATA_W-1:0]       value_q;
  logic [DATA_W-1:0]       conv_bin;
  logic                    pending_q, pending_clr;
  logic                    lead_zero_q, lead_zero_d;
  logic                    flag_d, frame_done_d;
  logic [6:0]              ascii_d;
  logic [8:0]              x_d, y_d;
  logic                    conv_start, bcd_done;
  logic [4*NUM_DIGITS-1:0] bcd;
  logic [6:0]              label_char;
  logic [3:0]              cur_digit;
  logic                    blank;

  assign en_size = (EN_SIZE != 0);
  assign busy    = !(state_q == ST_IDLE || state_q == ST_HOLD);
  // a strobe on the CONV entry edge is converted directly, so it needs no pending
  assign conv_bin = data_valid ? data_in : value_q;

  bin2bcd_seq #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (conv_start),
    .bin       (conv_bin),
    .done      (bcd_done),
    .bcd       (bcd)
  );

  always_comb begin
    label_char = TEXT[8*(STR_LEN-1-int'(str_idx_q)) +: 7];
    cur_digit  = bcd[4*(NUM_DIGITS-1-int'(dig_idx_q)) +: 4];
    blank      = (ZERO_SUPPRESS != 0) && lead_zero_q && (cur_digit == 4'd0) &&
                 (dig_idx_q != DIG_W'(NUM_DIGITS-1));
  end

  always_comb begin
    state_d      = state_q;
    str_idx_d    = str_idx_q;
    dig_idx_d    = dig_idx_q;
    lead_zero_d  = lead_zero_q;
    flag_d       = 1'b0;
    frame_done_d = 1'b0;
    ascii_d      = ascii_num;
    x_d          = start_x;
    y_d          = start_y;
    conv_start   = 1'b0;
    pending_clr  = 1'b0;
    if (!init_done) begin
      state_d   = ST_IDLE;
      str_idx_d = '0;
      dig_idx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_STR_REQ;
          str_idx_d = '0;
        end
        ST_STR_REQ: begin
          ascii_d = label_char;
          x_d     = 9'(STR_X0) + 9'(str_idx_q) * PITCH;
          y_d     = 9'(STR_Y0);
          flag_d  = 1'b1;
          state_d = ST_STR_WAIT;
        end
        ST_STR_WAIT: begin
          if (show_char_done) begin
            if (str_idx_q == 5'(STR_LEN-1)) begin
              state_d      = ST_CONV;
              frame_done_d = 1'b1;
              conv_start   = 1'b1;
              pending_clr  = 1'b1;
            end else begin
              str_idx_d = str_idx_q + 5'd1;
              state_d   = ST_STR_REQ;
            end
          end
        end
        ST_CONV: begin
          if (bcd_done) begin
            state_d     = ST_NUM_REQ;
            dig_idx_d   = '0;
            lead_zero_d = 1'b1;
          end
        end
        ST_NUM_REQ: begin
          ascii_d     = blank ? 7'(ASCII_SPACE) : 7'(ASCII_ZERO) + {3'b000, cur_digit};
          x_d         = 9'(NUM_X0) + 9'(dig_idx_q) * PITCH;
          y_d         = 9'(NUM_Y0);
          flag_d      = 1'b1;
          lead_zero_d = lead_zero_q && (cur_digit == 4'd0);
          state_d     = ST_NUM_WAIT;
        end
        ST_NUM_WAIT: begin
          if (show_char_done) begin
            if (dig_idx_q == DIG_W'(NUM_DIGITS-1)) begin
              state_d      = ST_HOLD;
              frame_done_d = 1'b1;
            end else begin
              dig_idx_d = dig_idx_q + DIG_W'(1);
              state_d   = ST_NUM_REQ;
            end
          end
        end
        ST_HOLD: begin
          if (pending_q || data_valid) begin
            state_d     = ST_CONV;
            conv_start  = 1'b1;
            pending_clr = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= ST_IDLE;
      str_idx_q      <= '0;
      dig_idx_q      <= '0;
      lead_zero_q    <= 1'b0;
      value_q        <= '0;
      pending_q      <= 1'b0;
      show_char_flag <= 1'b0;
      frame_done     <= 1'b0;
      ascii_num      <= '0;
      start_x        <= '0;
      start_y        <= '0;
    end else begin
      state_q        <= state_d;
      str_idx_q      <= str_idx_d;
      dig_idx_q      <= dig_idx_d;
      lead_zero_q    <= lead_zero_d;
      show_char_flag <= flag_d;
      frame_done     <= frame_done_d;
      ascii_num      <= ascii_d;
      start_x        <= x_d;
      start_y        <= y_d;
      if (data_valid) value_q <= data_in;
      if (pending_clr) pending_q <= 1'b0;
      else if (data_valid && state_q != ST_HOLD) pending_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_text_num_seq.sv
// Directed bench: three sequencer instances (defaults, no zero suppression, 16x8 "AB").
module tb_lcd_text_num_seq;

  typedef struct {
    int inst;
    int code;
    int x;
    int y;
    int busy;
  } ev_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       init[3];
  logic       dv[3];
  logic       stray[3];
  logic       ack[3];
  logic       ack_en[3];
  logic [15:0] din[3];
  logic       flag[3];
  logic       fdone[3];
  logic       busy[3];
  logic       en_sz[3];
  logic [6:0] ascii[3];
  logic [8:0] xs[3];
  logic [8:0] ys[3];
  int         ack_cnt[3];
  int         n_log[3];
  int         n_fd[3];
  ev_t        log_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  lcd_text_num_seq dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init[0]),
    .show_char_done(ack[0] | stray[0]), .data_in(din[0]), .data_valid(dv[0]),
    .en_size(en_sz[0]), .show_char_flag(flag[0]), .ascii_num(ascii[0]),
    .start_x(xs[0]), .start_y(ys[0]), .busy(busy[0]), .frame_done(fdone[0]));

  lcd_text_num_seq #(.ZERO_SUPPRESS(0)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init[1]),
    .show_char_done(ack[1] | stray[1]), .data_in(din[1]), .data_valid(dv[1]),
    .en_size(en_sz[1]), .show_char_flag(flag[1]), .ascii_num(ascii[1]),
    .start_x(xs[1]), .start_y(ys[1]), .busy(busy[1]), .frame_done(fdone[1]));

  lcd_text_num_seq #(.EN_SIZE(1), .STR_LEN(2), .TEXT("AB")) dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init[2]),
    .show_char_done(ack[2] | stray[2]), .data_in(din[2]), .data_valid(dv[2]),
    .en_size(en_sz[2]), .show_char_flag(flag[2]), .ascii_num(ascii[2]),
    .start_x(xs[2]), .start_y(ys[2]), .busy(busy[2]), .frame_done(fdone[2]));

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // renderer model: acknowledge each glyph a few cycles after its request
  initial forever begin
    @(posedge sys_clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      ack[g] = 1'b0;
      if (ack_cnt[g] != 0) begin
        ack_cnt[g]--;
        if (ack_cnt[g] == 0 && ack_en[g] === 1'b1) ack[g] = 1'b1;
      end else if (flag[g] === 1'b1) begin
        ack_cnt[g] = 3;
      end
    end
  end

  initial forever begin
    @(negedge sys_clk);
    for (int g = 0; g < 3; g++) begin
      if (flag[g] === 1'b1) begin
        log_q.push_back('{g, int'(ascii[g]), int'(xs[g]), int'(ys[g]), int'(busy[g])});
        n_log[g]++;
      end
      if (fdone[g] === 1'b1) n_fd[g]++;
    end
  end

  function automatic ev_t get_ev(input int g, input int k);
    ev_t r = '{-1, -1, -1, -1, -1};
    int  seen = 0;
    foreach (log_q[i]) begin
      if (log_q[i].inst == g) begin
        if (seen == k) r = log_q[i];
        seen++;
      end
    end
    return r;
  endfunction

  task automatic wait_until(input int g, input int nl, input int nf, input string tag);
    int cyc = 0;
    while ((n_log[g] < nl || n_fd[g] < nf) && cyc < 3000) begin
      @(posedge sys_clk);
      cyc++;
    end
    check_val({tag, "_flags"}, n_log[g], nl);
    check_val({tag, "_frames"}, n_fd[g], nf);
  endtask

  task automatic wait_flag(input int g, input int start, output int cycles);
    cycles = start;
    for (int i = 0; i < 400; i++) begin
      @(posedge sys_clk);
      cycles++;
      @(negedge sys_clk);
      if (flag[g] === 1'b1) break;
    end
  endtask

  task automatic check_digits(input string tag, input int g, input int k0,
                              input int d[5], input int pitch);
    ev_t e;
    for (int i = 0; i < 5; i++) begin
      e = get_ev(g, k0 + i);
      check_val($sformatf("%s_code%0d", tag, i), e.code, d[i]);
      check_val($sformatf("%s_x%0d", tag, i), e.x, 8 + pitch * i);
      check_val($sformatf("%s_y%0d", tag, i), e.y, 48);
    end
  endtask

  task automatic pulse_data(input int g, input int val);
    @(posedge sys_clk);
    #1;
    din[g] = 16'(val);
    dv[g]  = 1'b1;
    @(posedge sys_clk);
    #1;
    dv[g]  = 1'b0;
  endtask

  initial begin
    int  lbl[12] = '{82, 69, 68, 83, 84, 79, 78, 69, 66, 79, 79, 75};
    int  exp_d[5];
    int  cyc;
    int  base;
    int  nb;
    ev_t e;

    for (int g = 0; g < 3; g++) begin
      init[g] = 1'b0; dv[g] = 1'b0; stray[g] = 1'b0; ack_en[g] = 1'b1; din[g] = '0;
    end
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_val("rst_flag", int'(flag[0]), 0);
    check_val("rst_ascii", int'(ascii[0]), 0);
    check_val("rst_x", int'(xs[0]), 0);
    check_val("rst_y", int'(ys[0]), 0);
    check_val("rst_busy", int'(busy[0]), 0);
    check_val("rst_frame_done", int'(fdone[0]), 0);
    check_val("rst_en_size0", int'(en_sz[0]), 0);
    check_val("rst_en_size1", int'(en_sz[1]), 0);
    check_val("rst_en_size2", int'(en_sz[2]), 1);

    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    for (int g = 0; g < 3; g++) init[g] = 1'b1;
    wait_flag(0, 0, cyc);
    check_val("init_latency", cyc, 2);

    // default instance: full label then value 0
    wait_until(0, 17, 2, "d0_first");
    for (int i = 0; i < 12; i++) begin
      e = get_ev(0, i);
      check_val($sformatf("lbl_code%0d", i), e.code, lbl[i]);
      check_val($sformatf("lbl_x%0d", i), e.x, 72 + 6 * i);
      check_val($sformatf("lbl_y%0d", i), e.y, 16);
    end
    exp_d = '{32, 32, 32, 32, 48};
    check_digits("d0_zero", 0, 12, exp_d, 6);

    pulse_data(0, 1234);
    wait_flag(0, 1, cyc);
    check_val("hold_latency", cyc, 18);
    wait_until(0, 22, 3, "d0_1234");
    exp_d = '{32, 49, 50, 51, 52};
    check_digits("d0_1234", 0, 17, exp_d, 6);

    pulse_data(0, 65535);
    wait_until(0, 27, 4, "d0_65535");
    exp_d = '{54, 53, 53, 51, 53};
    check_digits("d0_65535", 0, 22, exp_d, 6);

    // no zero suppression
    wait_until(1, 17, 2, "nz_first");
    exp_d = '{48, 48, 48, 48, 48};
    check_digits("nz_zero", 1, 12, exp_d, 6);
    pulse_data(1, 7);
    wait_until(1, 22, 3, "nz_7");
    exp_d = '{48, 48, 48, 48, 55};
    check_digits("nz_7", 1, 17, exp_d, 6);

    // 16x8 font, two-character label
    wait_until(2, 7, 2, "ab_first");
    e = get_ev(2, 0);
    check_val("ab_code0", e.code, 65);
    check_val("ab_x0", e.x, 72);
    check_val("ab_y0", e.y, 16);
    e = get_ev(2, 1);
    check_val("ab_code1", e.code, 66);
    check_val("ab_x1", e.x, 80);
    exp_d = '{32, 32, 32, 32, 48};
    check_digits("ab_zero", 2, 2, exp_d, 8);
    nb = 0;
    foreach (log_q[i]) if (log_q[i].inst == 2 && log_q[i].busy != 1) nb++;
    check_val("ab_busy_at_flags", nb, 0);
    @(negedge sys_clk);
    check_val("ab_busy_after", int'(busy[2]), 0);
    check_val("ab_en_size", int'(en_sz[2]), 1);

    // init_done drop in the middle of label glyph 5
    @(posedge sys_clk);
    #1 init[0] = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 init[0] = 1'b1;
    base = 27;
    wait_until(0, base + 6, 4, "abort_reach");
    ack_en[0] = 1'b0;
    #1 init[0] = 1'b0;
    e = get_ev(0, base + 5);
    check_val("abort_idx5_code", e.code, 79);
    check_val("abort_idx5_x", e.x, 102);
    @(posedge sys_clk);
    #1 stray[0] = 1'b1;
    @(posedge sys_clk);
    #1 stray[0] = 1'b0;
    repeat (8) @(posedge sys_clk);
    @(negedge sys_clk);
    check_val("abort_no_flag", n_log[0], base + 6);
    check_val("abort_idle_busy", int'(busy[0]), 0);
    check_val("abort_flag_low", int'(flag[0]), 0);

    ack_en[0] = 1'b1;
    @(posedge sys_clk);
    #1 init[0] = 1'b1;
    wait_flag(0, 0, cyc);
    check_val("reinit_latency", cyc, 2);
    @(posedge sys_clk);
    e = get_ev(0, base + 6);
    check_val("reinit_code", e.code, 82);
    check_val("reinit_x", e.x, 72);

    // two strobes during the label pass collapse into one number pass
    repeat (10) @(posedge sys_clk);
    pulse_data(0, 9);
    repeat (5) @(posedge sys_clk);
    pulse_data(0, 42);
    wait_until(0, base + 23, 6, "collapse");
    exp_d = '{32, 32, 32, 52, 50};
    check_digits("collapse_42", 0, base + 18, exp_d, 6);
    repeat (100) @(posedge sys_clk);
    check_val("no_extra_pass_flags", n_log[0], base + 23);
    check_val("no_extra_pass_frames", n_fd[0], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
